// File: rtl/y86_pkg.sv
// Shared Y86 write-back definitions: instruction codes, special register IDs,
// sequencer state encoding and the captured request record.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP_ID = 4'h4;
  localparam logic [3:0] NOREG  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR1  = 2'd1,
    S_WR2  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_m;
  } wb_req_t;

endpackage

// File: rtl/wb_decode.sv
// Maps an instruction to its write-back destinations (E port then M port);
// NOREG on a port means that port does not write.
import y86_pkg::*;

module wb_decode (
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] dstE,
  output logic [3:0] dstM,
  output logic       two_write,
  output logic       illegal
);

  always_comb begin
    dstE      = NOREG;
    dstM      = NOREG;
    two_write = 1'b0;
    illegal   = 1'b0;
    case (icode)
      I_RRMOVQ:                 dstE = cnd ? rB : NOREG;
      I_IRMOVQ, I_OPQ:          dstE = rB;
      I_MRMOVQ:                 dstM = rA;
      I_CALL, I_RET, I_PUSHQ:   dstE = RSP_ID;
      I_POPQ: begin
        // %rsp update goes first so that popq %rsp leaves valM in %rsp
        dstE      = RSP_ID;
        dstM      = rA;
        two_write = 1'b1;
      end
      I_HALT, I_NOP, I_RMMOVQ, I_JXX: ;
      default:                  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Sequences Y86 write-backs onto a single registered register-file write port;
// popq is split into two consecutive writes (WR1 then WR2).
import y86_pkg::*;

module regfile_wb_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        halt,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        busy,
  output logic        func_error
);

  wb_state_e   state_q, state_d;
  wb_req_t     req_q, req_d;
  logic        rdy_en_q;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;

  logic        popq_q, accept;
  logic [3:0]  dst_e, dst_m;
  logic        two_wr, illegal;

  assign popq_q   = (req_q.icode == I_POPQ);
  assign wb_ready = rdy_en_q && !halt && (state_q != S_WR2) &&
                    !((state_q == S_WR1) && popq_q);
  assign accept   = wb_valid && wb_ready;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    if (accept) begin
      req_d.icode = icode;
      req_d.ra    = rA;
      req_d.rb    = rB;
      req_d.cnd   = cnd;
      req_d.val_e = valE;
      req_d.val_m = valM;
    end
    // halt freezes the sequencer where it is; accept is already blocked
    if (!halt) begin
      case (state_q)
        S_IDLE:  state_d = accept ? S_WR1 : S_IDLE;
        S_WR1:   state_d = popq_q ? S_WR2 : (accept ? S_WR1 : S_IDLE);
        S_WR2:   state_d = accept ? S_WR1 : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decode the request that will be current next cycle
  wb_decode u_decode (
    .icode     (req_d.icode),
    .rA        (req_d.ra),
    .rB        (req_d.rb),
    .cnd       (req_d.cnd),
    .dstE      (dst_e),
    .dstM      (dst_m),
    .two_write (two_wr),
    .illegal   (illegal)
  );

  always_comb begin
    we_d    = 1'b0;
    waddr_d = 4'h0;
    wdata_d = 64'h0;
    err_d   = err_q || (accept && illegal);
    // With halt low, entering WR1 means a fresh accept and entering WR2 means popq's second half
    if (!halt && (state_d == S_WR1)) begin
      if (dst_e != NOREG) begin
        we_d    = 1'b1;
        waddr_d = dst_e;
        wdata_d = req_d.val_e;
      end else if (!two_wr && (dst_m != NOREG)) begin
        we_d    = 1'b1;
        waddr_d = dst_m;
        wdata_d = req_d.val_m;
      end
    end else if (!halt && (state_d == S_WR2) && (dst_m != NOREG)) begin
      we_d    = 1'b1;
      waddr_d = dst_m;
      wdata_d = req_d.val_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      rdy_en_q <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 4'h0;
      wdata_q  <= 64'h0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rdy_en_q <= 1'b1;
      err_q    <= err_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign func_error = err_q;

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: directed scenarios then random traffic,
// compared cycle by cycle against a queue-of-writes reference model.
module tb_regfile_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  icode = 4'h0, rA = 4'h0, rB = 4'h0;
  logic        cnd = 1'b0;
  logic [63:0] valE = 64'h0, valM = 64'h0;
  logic        halt = 1'b0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        busy, func_error;

  regfile_wb_sequencer dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .icode(icode), .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
    .halt(halt), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .func_error(func_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: each accepted instruction becomes a list of write slots,
  // one slot consumed per non-halted clock edge.
  typedef struct {
    bit          we;
    logic [3:0]  a;
    logic [63:0] d;
  } slot_t;

  slot_t rem[$];
  slot_t out_m;
  int    cur_idx = -1;
  bit    rdy_en = 1'b0;
  bit    busy_m = 1'b0;
  bit    err_m  = 1'b0;

  function automatic slot_t mk(input bit we, input logic [3:0] a, input logic [63:0] d);
    slot_t s;
    s.we = we && (a != 4'hF);
    s.a  = s.we ? a : 4'h0;
    s.d  = s.we ? d : 64'h0;
    return s;
  endfunction

  function automatic void plan(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                               input bit c, input logic [63:0] ve, input logic [63:0] vm);
    case (ic)
      4'h2:             rem.push_back(mk(c, rb, ve));
      4'h3, 4'h6:       rem.push_back(mk(1'b1, rb, ve));
      4'h5:             rem.push_back(mk(1'b1, ra, vm));
      4'h8, 4'h9, 4'hA: rem.push_back(mk(1'b1, 4'h4, ve));
      4'hB: begin
        rem.push_back(mk(1'b1, 4'h4, ve));
        rem.push_back(mk(1'b1, ra, vm));
      end
      4'h0, 4'h1, 4'h4, 4'h7: rem.push_back(mk(1'b0, 4'h0, 64'h0));
      default: begin
        rem.push_back(mk(1'b0, 4'h0, 64'h0));
        err_m = 1'b1;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rf_we", {63'h0, rf_we}, {63'h0, out_m.we});
    chk("rf_waddr", {60'h0, rf_waddr}, {60'h0, out_m.a});
    chk("rf_wdata", rf_wdata, out_m.d);
    chk("busy", {63'h0, busy}, {63'h0, busy_m});
    chk("func_error", {63'h0, func_error}, {63'h0, err_m});
  endtask

  task automatic step(input bit v, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                      input bit c, input logic [63:0] ve, input logic [63:0] vm, input bit h);
    bit rdy_m, acc;
    wb_valid = v; icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; halt = h;
    @(negedge clk);
    rdy_m = rdy_en && !h && (rem.size() == 0) && (cur_idx < 1);
    chk("wb_ready", {63'h0, wb_ready}, {63'h0, rdy_m});
    acc = v && rdy_m;
    @(posedge clk);
    rdy_en = 1'b1;
    out_m  = mk(1'b0, 4'h0, 64'h0);
    if (!h) begin
      if (rem.size() > 0) begin
        out_m = rem.pop_front();
        cur_idx++;
        busy_m = 1'b1;
      end else if (acc) begin
        plan(ic, ra, rb, c, ve, vm);
        out_m   = rem.pop_front();
        cur_idx = 0;
        busy_m  = 1'b1;
      end else begin
        cur_idx = -1;
        busy_m  = 1'b0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit h = 1'b0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wb_valid = 1'b0;
    halt = 1'b0;
    #1;
    rem.delete();
    cur_idx = -1;
    busy_m  = 1'b0;
    err_m   = 1'b0;
    rdy_en  = 1'b0;
    out_m   = mk(1'b0, 4'h0, 64'h0);
    check_outputs();
    chk("ready_in_reset", {63'h0, wb_ready}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    idle();

    // irmovq $0x55, %rdx
    step(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0, 1'b0);
    chk("irmovq_we", {63'h0, rf_we}, 64'h1);
    chk("irmovq_addr", {60'h0, rf_waddr}, 64'h2);
    chk("irmovq_data", rf_wdata, 64'h55);
    idle();

    // popq %rbx: %rsp<-1031 then r3<-AB, not ready while in WR1
    step(1'b1, 4'hB, 4'h3, 4'hF, 1'b0, 64'd1031, 64'hAB, 1'b0);
    chk("popq_w1_addr", {60'h0, rf_waddr}, 64'h4);
    chk("popq_w1_data", rf_wdata, 64'd1031);
    chk("popq_wr1_ready", {63'h0, wb_ready}, 64'h0);
    idle();
    chk("popq_w2_addr", {60'h0, rf_waddr}, 64'h3);
    chk("popq_w2_data", rf_wdata, 64'hAB);
    idle();

    // cmov not taken, then taken
    step(1'b1, 4'h2, 4'hF, 4'h1, 1'b0, 64'h99, 64'h0, 1'b0);
    chk("cmov_nt_we", {63'h0, rf_we}, 64'h0);
    step(1'b1, 4'h2, 4'hF, 4'h1, 1'b1, 64'h7, 64'h0, 1'b0);
    chk("cmov_t_data", rf_wdata, 64'h7);
    idle();

    // popq %rsp: valM must land last
    step(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h8, 64'h9, 1'b0);
    chk("popq_rsp_w1", rf_wdata, 64'h8);
    idle();
    chk("popq_rsp_w2", rf_wdata, 64'h9);
    idle();

    // back-to-back accepts, plus a NOREG destination
    step(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h1111, 64'h0, 1'b0);
    step(1'b1, 4'h6, 4'hF, 4'h6, 1'b0, 64'h2222, 64'h0, 1'b0);
    step(1'b1, 4'h5, 4'h7, 4'hF, 1'b0, 64'h0, 64'h3333, 1'b0);
    step(1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 64'h4444, 64'h0, 1'b0);
    step(1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'h5555, 64'h0, 1'b0);
    step(1'b1, 4'h1, 4'h2, 4'h3, 1'b1, 64'h6666, 64'h7777, 1'b0);
    idle();

    // illegal icode: sticky error, no write
    step(1'b1, 4'hD, 4'h1, 4'h2, 1'b1, 64'hDEAD, 64'hBEEF, 1'b0);
    chk("illegal_err", {63'h0, func_error}, 64'h1);
    idle(); idle(); idle();
    chk("illegal_sticky", {63'h0, func_error}, 64'h1);

    // halt three cycles before popq's second write
    step(1'b1, 4'hB, 4'h5, 4'hF, 1'b0, 64'h100, 64'h200, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);
    idle();
    chk("halt_release_data", rf_wdata, 64'h200);
    idle();

    // halt while sitting in WR2
    step(1'b1, 4'hB, 4'h6, 4'hF, 1'b0, 64'h300, 64'h400, 1'b0);
    idle();
    idle(1'b1); idle(1'b1);
    idle(); idle();

    // reset during WR1 of popq drops the second write
    step(1'b1, 4'hB, 4'h3, 4'hF, 1'b0, 64'h500, 64'h600, 1'b0);
    do_reset();
    idle(); idle(); idle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 9) == 0);
      end
    end
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
